// File: rtl/mem_axi_arb_pkg.sv
// Shared widths, request bundle and ID tagging for the 2:1 AXI memory arbiter.
// Master index is carried in slave ID bit [AXI_MID_W].
package mem_axi_arb_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_MID_W  = 4;
  localparam int AXI_SID_W  = 6;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [AXI_SID_W-1:0]  id;
  } ax_req_t;

  function automatic logic [AXI_SID_W-1:0] tag_id(
    input logic                 idx,
    input logic [AXI_MID_W-1:0] id
  );
    return {{(AXI_SID_W-AXI_MID_W-1){1'b0}}, idx, id};
  endfunction

endpackage

// File: rtl/mem_axi_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; priority moves to the other
// requester after every accepted grant.
module rr_arb2
  import mem_axi_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      ptr <= M0;
    else if (accept && grant != 2'b00)
      ptr <= grant[0];
  end

endmodule

// File: rtl/mem_axi_arbiter.sv
// 2:1 AXI4 arbiter in front of the DDR port: registered AR/AW slices,
// W steering locked to the last AW winner, ID-routed B/R return.
module mem_axi_arbiter
  import mem_axi_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic m0_ar_valid, output logic m0_ar_ready,
  input  logic [AXI_MID_W-1:0]  m0_ar_id,
  input  logic [AXI_ADDR_W-1:0] m0_ar_addr,
  input  logic [7:0] m0_ar_len, input logic [2:0] m0_ar_size,
  input  logic [1:0] m0_ar_burst, input logic m0_ar_lock,
  input  logic [3:0] m0_ar_cache, input logic [2:0] m0_ar_prot,
  input  logic [3:0] m0_ar_qos,
  input  logic m1_ar_valid, output logic m1_ar_ready,
  input  logic [AXI_MID_W-1:0]  m1_ar_id,
  input  logic [AXI_ADDR_W-1:0] m1_ar_addr,
  input  logic [7:0] m1_ar_len, input logic [2:0] m1_ar_size,
  input  logic [1:0] m1_ar_burst, input logic m1_ar_lock,
  input  logic [3:0] m1_ar_cache, input logic [2:0] m1_ar_prot,
  input  logic [3:0] m1_ar_qos,
  input  logic m0_aw_valid, output logic m0_aw_ready,
  input  logic [AXI_MID_W-1:0]  m0_aw_id,
  input  logic [AXI_ADDR_W-1:0] m0_aw_addr,
  input  logic [7:0] m0_aw_len, input logic [2:0] m0_aw_size,
  input  logic [1:0] m0_aw_burst, input logic m0_aw_lock,
  input  logic [3:0] m0_aw_cache, input logic [2:0] m0_aw_prot,
  input  logic [3:0] m0_aw_qos,
  input  logic m1_aw_valid, output logic m1_aw_ready,
  input  logic [AXI_MID_W-1:0]  m1_aw_id,
  input  logic [AXI_ADDR_W-1:0] m1_aw_addr,
  input  logic [7:0] m1_aw_len, input logic [2:0] m1_aw_size,
  input  logic [1:0] m1_aw_burst, input logic m1_aw_lock,
  input  logic [3:0] m1_aw_cache, input logic [2:0] m1_aw_prot,
  input  logic [3:0] m1_aw_qos,
  input  logic m0_w_valid, output logic m0_w_ready,
  input  logic [AXI_DATA_W-1:0] m0_w_data,
  input  logic [AXI_STRB_W-1:0] m0_w_strb, input logic m0_w_last,
  input  logic m1_w_valid, output logic m1_w_ready,
  input  logic [AXI_DATA_W-1:0] m1_w_data,
  input  logic [AXI_STRB_W-1:0] m1_w_strb, input logic m1_w_last,
  output logic m0_b_valid, input logic m0_b_ready,
  output logic [AXI_MID_W-1:0] m0_b_id, output logic [1:0] m0_b_resp,
  output logic m1_b_valid, input logic m1_b_ready,
  output logic [AXI_MID_W-1:0] m1_b_id, output logic [1:0] m1_b_resp,
  output logic m0_r_valid, input logic m0_r_ready,
  output logic [AXI_MID_W-1:0]  m0_r_id,
  output logic [AXI_DATA_W-1:0] m0_r_data,
  output logic [1:0] m0_r_resp, output logic m0_r_last,
  output logic m1_r_valid, input logic m1_r_ready,
  output logic [AXI_MID_W-1:0]  m1_r_id,
  output logic [AXI_DATA_W-1:0] m1_r_data,
  output logic [1:0] m1_r_resp, output logic m1_r_last,
  output logic s_ar_valid, input logic s_ar_ready,
  output logic [AXI_SID_W-1:0]  s_ar_id,
  output logic [AXI_ADDR_W-1:0] s_ar_addr,
  output logic [7:0] s_ar_len, output logic [2:0] s_ar_size,
  output logic [1:0] s_ar_burst, output logic s_ar_lock,
  output logic [3:0] s_ar_cache, output logic [2:0] s_ar_prot,
  output logic [3:0] s_ar_qos,
  output logic s_aw_valid, input logic s_aw_ready,
  output logic [AXI_SID_W-1:0]  s_aw_id,
  output logic [AXI_ADDR_W-1:0] s_aw_addr,
  output logic [7:0] s_aw_len, output logic [2:0] s_aw_size,
  output logic [1:0] s_aw_burst, output logic s_aw_lock,
  output logic [3:0] s_aw_cache, output logic [2:0] s_aw_prot,
  output logic [3:0] s_aw_qos,
  output logic s_w_valid, input logic s_w_ready,
  output logic [AXI_DATA_W-1:0] s_w_data,
  output logic [AXI_STRB_W-1:0] s_w_strb, output logic s_w_last,
  input  logic s_b_valid, output logic s_b_ready,
  input  logic [AXI_SID_W-1:0] s_b_id, input logic [1:0] s_b_resp,
  input  logic s_r_valid, output logic s_r_ready,
  input  logic [AXI_SID_W-1:0]  s_r_id,
  input  logic [AXI_DATA_W-1:0] s_r_data,
  input  logic [1:0] s_r_resp, input logic s_r_last
);

  logic [1:0] ar_gnt, aw_gnt;
  logic       ar_en, aw_en;
  logic       ar_full, aw_full;
  ax_req_t    ar_q, aw_q, ar_in, aw_in;
  logic       w_busy, w_owner, w_done;

  // A full slice may still take a new request when it drains this cycle.
  assign ar_en = !reset && (!ar_full || s_ar_ready);
  assign w_done = w_busy && s_w_valid && s_w_ready && s_w_last;
  assign aw_en = !reset && (!aw_full || s_aw_ready)
              && (!w_busy || w_done);

  rr_arb2 u_ar_arb (
    .clock(clock), .reset(reset),
    .req({m1_ar_valid, m0_ar_valid}),
    .enable(ar_en), .accept(ar_en), .grant(ar_gnt)
  );

  rr_arb2 u_aw_arb (
    .clock(clock), .reset(reset),
    .req({m1_aw_valid, m0_aw_valid}),
    .enable(aw_en), .accept(aw_en), .grant(aw_gnt)
  );

  assign m0_ar_ready = ar_gnt[0];
  assign m1_ar_ready = ar_gnt[1];
  assign m0_aw_ready = aw_gnt[0];
  assign m1_aw_ready = aw_gnt[1];

  always_comb begin
    ar_in = '0;
    if (ar_gnt[1]) begin
      ar_in.addr  = m1_ar_addr;  ar_in.len  = m1_ar_len;
      ar_in.size  = m1_ar_size;  ar_in.burst = m1_ar_burst;
      ar_in.lock  = m1_ar_lock;  ar_in.cache = m1_ar_cache;
      ar_in.prot  = m1_ar_prot;  ar_in.qos  = m1_ar_qos;
      ar_in.id    = tag_id(M1, m1_ar_id);
    end else begin
      ar_in.addr  = m0_ar_addr;  ar_in.len  = m0_ar_len;
      ar_in.size  = m0_ar_size;  ar_in.burst = m0_ar_burst;
      ar_in.lock  = m0_ar_lock;  ar_in.cache = m0_ar_cache;
      ar_in.prot  = m0_ar_prot;  ar_in.qos  = m0_ar_qos;
      ar_in.id    = tag_id(M0, m0_ar_id);
    end
  end

  always_comb begin
    aw_in = '0;
    if (aw_gnt[1]) begin
      aw_in.addr  = m1_aw_addr;  aw_in.len  = m1_aw_len;
      aw_in.size  = m1_aw_size;  aw_in.burst = m1_aw_burst;
      aw_in.lock  = m1_aw_lock;  aw_in.cache = m1_aw_cache;
      aw_in.prot  = m1_aw_prot;  aw_in.qos  = m1_aw_qos;
      aw_in.id    = tag_id(M1, m1_aw_id);
    end else begin
      aw_in.addr  = m0_aw_addr;  aw_in.len  = m0_aw_len;
      aw_in.size  = m0_aw_size;  aw_in.burst = m0_aw_burst;
      aw_in.lock  = m0_aw_lock;  aw_in.cache = m0_aw_cache;
      aw_in.prot  = m0_aw_prot;  aw_in.qos  = m0_aw_qos;
      aw_in.id    = tag_id(M0, m0_aw_id);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ar_full <= 1'b0; ar_q <= '0;
      aw_full <= 1'b0; aw_q <= '0;
      w_busy  <= 1'b0; w_owner <= M0;
    end else begin
      if (ar_gnt != 2'b00) begin
        ar_full <= 1'b1; ar_q <= ar_in;
      end else if (s_ar_ready) begin
        ar_full <= 1'b0;
      end
      if (aw_gnt != 2'b00) begin
        aw_full <= 1'b1; aw_q <= aw_in;
        w_busy  <= 1'b1; w_owner <= aw_gnt[1];
      end else begin
        if (s_aw_ready) aw_full <= 1'b0;
        if (w_done)     w_busy  <= 1'b0;
      end
    end
  end

  assign s_ar_valid = ar_full;
  assign s_ar_id    = ar_q.id;    assign s_ar_addr  = ar_q.addr;
  assign s_ar_len   = ar_q.len;   assign s_ar_size  = ar_q.size;
  assign s_ar_burst = ar_q.burst; assign s_ar_lock  = ar_q.lock;
  assign s_ar_cache = ar_q.cache; assign s_ar_prot  = ar_q.prot;
  assign s_ar_qos   = ar_q.qos;

  assign s_aw_valid = aw_full;
  assign s_aw_id    = aw_q.id;    assign s_aw_addr  = aw_q.addr;
  assign s_aw_len   = aw_q.len;   assign s_aw_size  = aw_q.size;
  assign s_aw_burst = aw_q.burst; assign s_aw_lock  = aw_q.lock;
  assign s_aw_cache = aw_q.cache; assign s_aw_prot  = aw_q.prot;
  assign s_aw_qos   = aw_q.qos;

  assign s_w_valid = w_busy && (w_owner ? m1_w_valid : m0_w_valid);
  assign s_w_data  = w_owner ? m1_w_data : m0_w_data;
  assign s_w_strb  = w_owner ? m1_w_strb : m0_w_strb;
  assign s_w_last  = w_owner ? m1_w_last : m0_w_last;
  assign m0_w_ready = w_busy && !w_owner && s_w_ready;
  assign m1_w_ready = w_busy &&  w_owner && s_w_ready;

  logic b_sel, r_sel;
  assign b_sel = s_b_id[AXI_MID_W];
  assign r_sel = s_r_id[AXI_MID_W];

  assign m0_b_valid = s_b_valid && !b_sel;
  assign m1_b_valid = s_b_valid &&  b_sel;
  assign m0_b_id    = s_b_id[AXI_MID_W-1:0];
  assign m1_b_id    = s_b_id[AXI_MID_W-1:0];
  assign m0_b_resp  = s_b_resp;
  assign m1_b_resp  = s_b_resp;
  assign s_b_ready  = b_sel ? m1_b_ready : m0_b_ready;

  assign m0_r_valid = s_r_valid && !r_sel;
  assign m1_r_valid = s_r_valid &&  r_sel;
  assign m0_r_id    = s_r_id[AXI_MID_W-1:0];
  assign m1_r_id    = s_r_id[AXI_MID_W-1:0];
  assign m0_r_data  = s_r_data;   assign m1_r_data = s_r_data;
  assign m0_r_resp  = s_r_resp;   assign m1_r_resp = s_r_resp;
  assign m0_r_last  = s_r_last;   assign m1_r_last = s_r_last;
  assign s_r_ready  = r_sel ? m1_r_ready : m0_r_ready;

  // Slave must echo only IDs we issued; stray upper bits are still routed.
  generate
    if (AXI_SID_W > AXI_MID_W + 1) begin : g_id_chk
      a_rid: assert property (@(posedge clock) disable iff (reset)
        s_r_valid |-> s_r_id[AXI_SID_W-1:AXI_MID_W+1] == '0);
      a_bid: assert property (@(posedge clock) disable iff (reset)
        s_b_valid |-> s_b_id[AXI_SID_W-1:AXI_MID_W+1] == '0);
    end
  endgenerate

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Bench for mem_axi_arbiter: directed scenarios plus randomized AR
// arbitration and B/R routing against a queue-based reference model.
module tb_mem_axi_arbiter;
  import mem_axi_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic m0_ar_valid, m0_ar_ready, m0_ar_lock;
  logic [3:0] m0_ar_id, m0_ar_cache, m0_ar_qos;
  logic [31:0] m0_ar_addr; logic [7:0] m0_ar_len;
  logic [2:0] m0_ar_size, m0_ar_prot; logic [1:0] m0_ar_burst;
  logic m1_ar_valid, m1_ar_ready, m1_ar_lock;
  logic [3:0] m1_ar_id, m1_ar_cache, m1_ar_qos;
  logic [31:0] m1_ar_addr; logic [7:0] m1_ar_len;
  logic [2:0] m1_ar_size, m1_ar_prot; logic [1:0] m1_ar_burst;
  logic m0_aw_valid, m0_aw_ready, m0_aw_lock;
  logic [3:0] m0_aw_id, m0_aw_cache, m0_aw_qos;
  logic [31:0] m0_aw_addr; logic [7:0] m0_aw_len;
  logic [2:0] m0_aw_size, m0_aw_prot; logic [1:0] m0_aw_burst;
  logic m1_aw_valid, m1_aw_ready, m1_aw_lock;
  logic [3:0] m1_aw_id, m1_aw_cache, m1_aw_qos;
  logic [31:0] m1_aw_addr; logic [7:0] m1_aw_len;
  logic [2:0] m1_aw_size, m1_aw_prot; logic [1:0] m1_aw_burst;
  logic m0_w_valid, m0_w_ready, m0_w_last;
  logic [63:0] m0_w_data; logic [7:0] m0_w_strb;
  logic m1_w_valid, m1_w_ready, m1_w_last;
  logic [63:0] m1_w_data; logic [7:0] m1_w_strb;
  logic m0_b_valid, m0_b_ready, m1_b_valid, m1_b_ready;
  logic [3:0] m0_b_id, m1_b_id; logic [1:0] m0_b_resp, m1_b_resp;
  logic m0_r_valid, m0_r_ready, m0_r_last;
  logic [3:0] m0_r_id; logic [63:0] m0_r_data; logic [1:0] m0_r_resp;
  logic m1_r_valid, m1_r_ready, m1_r_last;
  logic [3:0] m1_r_id; logic [63:0] m1_r_data; logic [1:0] m1_r_resp;
  logic s_ar_valid, s_ar_ready, s_ar_lock;
  logic [5:0] s_ar_id; logic [31:0] s_ar_addr; logic [7:0] s_ar_len;
  logic [2:0] s_ar_size, s_ar_prot; logic [1:0] s_ar_burst;
  logic [3:0] s_ar_cache, s_ar_qos;
  logic s_aw_valid, s_aw_ready, s_aw_lock;
  logic [5:0] s_aw_id; logic [31:0] s_aw_addr; logic [7:0] s_aw_len;
  logic [2:0] s_aw_size, s_aw_prot; logic [1:0] s_aw_burst;
  logic [3:0] s_aw_cache, s_aw_qos;
  logic s_w_valid, s_w_ready, s_w_last;
  logic [63:0] s_w_data; logic [7:0] s_w_strb;
  logic s_b_valid, s_b_ready; logic [5:0] s_b_id; logic [1:0] s_b_resp;
  logic s_r_valid, s_r_ready, s_r_last;
  logic [5:0] s_r_id; logic [63:0] s_r_data; logic [1:0] s_r_resp;

  mem_axi_arbiter dut (
    .clock, .reset,
    .m0_ar_valid, .m0_ar_ready, .m0_ar_id, .m0_ar_addr, .m0_ar_len,
    .m0_ar_size, .m0_ar_burst, .m0_ar_lock, .m0_ar_cache,
    .m0_ar_prot, .m0_ar_qos,
    .m1_ar_valid, .m1_ar_ready, .m1_ar_id, .m1_ar_addr, .m1_ar_len,
    .m1_ar_size, .m1_ar_burst, .m1_ar_lock, .m1_ar_cache,
    .m1_ar_prot, .m1_ar_qos,
    .m0_aw_valid, .m0_aw_ready, .m0_aw_id, .m0_aw_addr, .m0_aw_len,
    .m0_aw_size, .m0_aw_burst, .m0_aw_lock, .m0_aw_cache,
    .m0_aw_prot, .m0_aw_qos,
    .m1_aw_valid, .m1_aw_ready, .m1_aw_id, .m1_aw_addr, .m1_aw_len,
    .m1_aw_size, .m1_aw_burst, .m1_aw_lock, .m1_aw_cache,
    .m1_aw_prot, .m1_aw_qos,
    .m0_w_valid, .m0_w_ready, .m0_w_data, .m0_w_strb, .m0_w_last,
    .m1_w_valid, .m1_w_ready, .m1_w_data, .m1_w_strb, .m1_w_last,
    .m0_b_valid, .m0_b_ready, .m0_b_id, .m0_b_resp,
    .m1_b_valid, .m1_b_ready, .m1_b_id, .m1_b_resp,
    .m0_r_valid, .m0_r_ready, .m0_r_id, .m0_r_data, .m0_r_resp,
    .m0_r_last,
    .m1_r_valid, .m1_r_ready, .m1_r_id, .m1_r_data, .m1_r_resp,
    .m1_r_last,
    .s_ar_valid, .s_ar_ready, .s_ar_id, .s_ar_addr, .s_ar_len,
    .s_ar_size, .s_ar_burst, .s_ar_lock, .s_ar_cache,
    .s_ar_prot, .s_ar_qos,
    .s_aw_valid, .s_aw_ready, .s_aw_id, .s_aw_addr, .s_aw_len,
    .s_aw_size, .s_aw_burst, .s_aw_lock, .s_aw_cache,
    .s_aw_prot, .s_aw_qos,
    .s_w_valid, .s_w_ready, .s_w_data, .s_w_strb, .s_w_last,
    .s_b_valid, .s_b_ready, .s_b_id, .s_b_resp,
    .s_r_valid, .s_r_ready, .s_r_id, .s_r_data, .s_r_resp, .s_r_last
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [5:0]  id;
  } exp_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    {m0_ar_valid, m0_ar_id, m0_ar_addr, m0_ar_len, m0_ar_size} = '0;
    {m0_ar_burst, m0_ar_lock, m0_ar_cache, m0_ar_prot, m0_ar_qos} = '0;
    {m1_ar_valid, m1_ar_id, m1_ar_addr, m1_ar_len, m1_ar_size} = '0;
    {m1_ar_burst, m1_ar_lock, m1_ar_cache, m1_ar_prot, m1_ar_qos} = '0;
    {m0_aw_valid, m0_aw_id, m0_aw_addr, m0_aw_len, m0_aw_size} = '0;
    {m0_aw_burst, m0_aw_lock, m0_aw_cache, m0_aw_prot, m0_aw_qos} = '0;
    {m1_aw_valid, m1_aw_id, m1_aw_addr, m1_aw_len, m1_aw_size} = '0;
    {m1_aw_burst, m1_aw_lock, m1_aw_cache, m1_aw_prot, m1_aw_qos} = '0;
    {m0_w_valid, m0_w_data, m0_w_strb, m0_w_last} = '0;
    {m1_w_valid, m1_w_data, m1_w_strb, m1_w_last} = '0;
    {m0_b_ready, m1_b_ready, m0_r_ready, m1_r_ready} = '0;
    {s_ar_ready, s_aw_ready, s_w_ready} = '0;
    {s_b_valid, s_b_id, s_b_resp} = '0;
    {s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    m0_ar_valid = 1; m1_ar_valid = 1; m0_aw_valid = 1; m1_aw_valid = 1;
    m0_w_valid = 1; m1_w_valid = 1; s_w_ready = 1;
    step();
    step();
    checks++;
    if ({s_ar_valid, s_aw_valid, s_w_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_slave_valid: got %b want 000",
               {s_ar_valid, s_aw_valid, s_w_valid});
    end
    checks++;
    if ({m0_ar_ready, m1_ar_ready, m0_aw_ready, m1_aw_ready,
         m0_w_ready, m1_w_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_master_ready: got %b want 000000",
               {m0_ar_ready, m1_ar_ready, m0_aw_ready, m1_aw_ready,
                m0_w_ready, m1_w_ready});
    end
    do_reset();
  endtask

  task automatic test_ar_single();
    logic [63:0] d;
    do_reset();
    m0_ar_valid = 1; m0_ar_addr = 32'h0000_1000; m0_ar_len = 8'd3;
    m0_ar_id = 4'd5; m0_ar_size = 3'd3; m0_ar_burst = 2'd1;
    #1;
    checks++;
    if ({m0_ar_ready, m1_ar_ready, s_ar_valid} !== 3'b100) begin
      errors++;
      $display("FAIL ar1_grant: got %b want 100",
               {m0_ar_ready, m1_ar_ready, s_ar_valid});
    end
    step();
    m0_ar_valid = 0;
    #1;
    checks++;
    if (s_ar_valid !== 1'b1 || s_ar_id !== 6'h05 ||
        s_ar_addr !== 32'h0000_1000 || s_ar_len !== 8'd3) begin
      errors++;
      $display("FAIL ar1_slave: got v%b id%h a%h l%0d want v1 id05 a00001000 l3",
               s_ar_valid, s_ar_id, s_ar_addr, s_ar_len);
    end
    s_ar_ready = 1;
    step();
    s_ar_ready = 0;
    m0_r_ready = 1; m1_r_ready = 1;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      s_r_valid = 1; s_r_id = 6'h05; s_r_data = d; s_r_last = (i == 3);
      #1;
      checks++;
      if (m0_r_valid !== 1'b1 || m1_r_valid !== 1'b0 ||
          m0_r_id !== 4'd5 || m0_r_data !== d ||
          m0_r_last !== (i == 3) || s_r_ready !== 1'b1) begin
        errors++;
        $display("FAIL ar1_rbeat%0d: got v%b%b id%h l%b rdy%b want v10 id5 l%b rdy1",
                 i, m0_r_valid, m1_r_valid, m0_r_id, m0_r_last, s_r_ready,
                 i == 3);
      end
      step();
    end
    s_r_valid = 0; s_r_last = 0;
  endtask

  task automatic test_ar_rr();
    logic pri, w, pw;
    logic [3:0] pid;
    do_reset();
    pri = 0; pw = 0; pid = 0;
    s_ar_ready = 1; m0_ar_valid = 1; m1_ar_valid = 1;
    for (int c = 0; c < 5; c++) begin
      m0_ar_id = 4'(c); m1_ar_id = 4'(c + 8);
      #1;
      w = pri;
      checks++;
      if (m0_ar_ready !== !w || m1_ar_ready !== w) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b%b want %b%b",
                 c, m1_ar_ready, m0_ar_ready, w, !w);
      end
      if (c > 0) begin
        checks++;
        if (s_ar_id !== 6'(pid) + (pw ? 6'd16 : 6'd0)) begin
          errors++;
          $display("FAIL rr_sid%0d: got %h want %h",
                   c, s_ar_id, 6'(pid) + (pw ? 6'd16 : 6'd0));
        end
      end
      pw = w;
      pid = w ? m1_ar_id : m0_ar_id;
      pri = !w;
      step();
    end
    m0_ar_valid = 0; m1_ar_valid = 0; s_ar_ready = 0;
  endtask

  task automatic test_random_ar();
    exp_t q[$];
    exp_t p0, p1, e;
    logic v0, v1, pri, rdy, g0, g1, can;
    do_reset();
    v0 = 0; v1 = 0; pri = 0;
    p0 = '{default: '0}; p1 = '{default: '0};
    for (int c = 0; c < 200; c++) begin
      if (!v0 && $urandom_range(0, 1) == 1) begin
        v0 = 1; p0.addr = $urandom; p0.len = 8'($urandom);
        p0.size = 3'($urandom); p0.id = 6'($urandom_range(0, 15));
      end
      if (!v1 && $urandom_range(0, 1) == 1) begin
        v1 = 1; p1.addr = $urandom; p1.len = 8'($urandom);
        p1.size = 3'($urandom); p1.id = 6'($urandom_range(0, 15));
      end
      m0_ar_valid = v0; m0_ar_addr = p0.addr; m0_ar_len = p0.len;
      m0_ar_size = p0.size; m0_ar_id = p0.id[3:0];
      m1_ar_valid = v1; m1_ar_addr = p1.addr; m1_ar_len = p1.len;
      m1_ar_size = p1.size; m1_ar_id = p1.id[3:0];
      rdy = 1'($urandom_range(0, 1));
      s_ar_ready = rdy;
      #1;
      can = (q.size() == 0) || rdy;
      g0 = 0; g1 = 0;
      if (can && v0 && v1) begin
        g0 = !pri; g1 = pri;
      end else if (can) begin
        g0 = v0; g1 = v1;
      end
      checks++;
      if (m0_ar_ready !== g0 || m1_ar_ready !== g1) begin
        errors++;
        $display("FAIL rand_ar_grant c%0d: got %b%b want %b%b",
                 c, m1_ar_ready, m0_ar_ready, g1, g0);
      end
      checks++;
      if (s_ar_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_ar_valid c%0d: got %b want %b",
                 c, s_ar_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        e = q[0];
        checks++;
        if (s_ar_addr !== e.addr || s_ar_len !== e.len ||
            s_ar_size !== e.size || s_ar_id !== e.id) begin
          errors++;
          $display("FAIL rand_ar_payload c%0d: got a%h l%h s%h id%h want a%h l%h s%h id%h",
                   c, s_ar_addr, s_ar_len, s_ar_size, s_ar_id,
                   e.addr, e.len, e.size, e.id);
        end
        if (rdy) void'(q.pop_front());
      end
      if (g0) begin
        q.push_back(p0); v0 = 0; pri = 1;
      end
      if (g1) begin
        e = p1; e.id = p1.id + 6'd16;
        q.push_back(e); v1 = 0; pri = 0;
      end
      step();
    end
    m0_ar_valid = 0; m1_ar_valid = 0; s_ar_ready = 0;
  endtask

  task automatic test_aw_order();
    logic [63:0] d;
    do_reset();
    s_aw_ready = 1; s_w_ready = 1;
    m1_aw_valid = 1; m1_aw_len = 8'd7; m1_aw_id = 4'd2;
    m1_aw_addr = $urandom;
    #1;
    checks++;
    if (m1_aw_ready !== 1'b1) begin
      errors++;
      $display("FAIL aw_m1_grant: got %b want 1", m1_aw_ready);
    end
    step();
    m1_aw_valid = 0;
    m0_aw_valid = 1; m0_aw_id = 4'd9; m0_aw_addr = $urandom;
    m0_w_valid = 1; m0_w_data = 64'hdead_beef; m0_w_last = 1;
    for (int b = 0; b < 8; b++) begin
      d = {$urandom, $urandom};
      m1_w_valid = 1; m1_w_data = d; m1_w_last = (b == 7);
      #1;
      if (b == 0) begin
        checks++;
        if (s_aw_valid !== 1'b1 || s_aw_id !== 6'h12) begin
          errors++;
          $display("FAIL aw_m1_slave: got v%b id%h want v1 id12",
                   s_aw_valid, s_aw_id);
        end
      end
      checks++;
      if (m0_aw_ready !== (b == 7) || m0_w_ready !== 1'b0 ||
          m1_w_ready !== 1'b1 || s_w_valid !== 1'b1 ||
          s_w_data !== d || s_w_last !== (b == 7)) begin
        errors++;
        $display("FAIL aw_order_beat%0d: got awr%b w0r%b w1r%b sv%b sl%b want awr%b w0r0 w1r1 sv1 sl%b",
                 b, m0_aw_ready, m0_w_ready, m1_w_ready, s_w_valid,
                 s_w_last, b == 7, b == 7);
      end
      step();
    end
    m0_aw_valid = 0; m1_w_valid = 0; m1_w_last = 0;
    #1;
    checks++;
    if (m0_w_ready !== 1'b1 || m1_w_ready !== 1'b0 ||
        s_w_data !== 64'hdead_beef || s_aw_id !== 6'h09) begin
      errors++;
      $display("FAIL aw_m0_after: got w0r%b w1r%b d%h id%h want w0r1 w1r0 ddeadbeef id09",
               m0_w_ready, m1_w_ready, s_w_data, s_aw_id);
    end
    step();
    m0_w_valid = 0; m0_w_last = 0;
    s_aw_ready = 0; s_w_ready = 0;
  endtask

  task automatic test_ar_stall();
    logic [31:0] a0, a1;
    do_reset();
    a0 = $urandom; a1 = $urandom;
    m0_ar_valid = 1; m0_ar_addr = a0; m0_ar_id = 4'd7; m0_ar_len = 8'd1;
    #1;
    checks++;
    if (m0_ar_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_first: got %b want 1", m0_ar_ready);
    end
    step();
    m0_ar_addr = $urandom; m0_ar_id = 4'd1;
    m1_ar_valid = 1; m1_ar_addr = a1; m1_ar_id = 4'd4;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (s_ar_valid !== 1'b1 || s_ar_addr !== a0 || s_ar_id !== 6'h07 ||
          m0_ar_ready !== 1'b0 || m1_ar_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got v%b a%h id%h r%b%b want v1 a%h id07 r00",
                 c, s_ar_valid, s_ar_addr, s_ar_id, m1_ar_ready,
                 m0_ar_ready, a0);
      end
      step();
    end
    s_ar_ready = 1;
    #1;
    checks++;
    if (m1_ar_ready !== 1'b1 || m0_ar_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_refill: got %b%b want 10", m1_ar_ready, m0_ar_ready);
    end
    step();
    m1_ar_valid = 0; m0_ar_valid = 0; s_ar_ready = 0;
    #1;
    checks++;
    if (s_ar_addr !== a1 || s_ar_id !== 6'h14) begin
      errors++;
      $display("FAIL stall_next: got a%h id%h want a%h id14",
               s_ar_addr, s_ar_id, a1);
    end
  endtask

  task automatic test_r_interleave();
    logic r0, r1, sel;
    logic [5:0] id;
    logic [63:0] d;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      id = (i % 2 == 0) ? 6'h03 : 6'h13;
      d = {$urandom, $urandom};
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      m0_r_ready = r0; m1_r_ready = r1;
      s_r_valid = 1; s_r_id = id; s_r_data = d; s_r_last = 1'($urandom);
      #1;
      sel = (id >= 6'd16);
      checks++;
      if (m0_r_valid !== !sel || m1_r_valid !== sel ||
          (sel ? m1_r_id : m0_r_id) !== 4'd3 ||
          (sel ? m1_r_data : m0_r_data) !== d ||
          s_r_ready !== (sel ? r1 : r0)) begin
        errors++;
        $display("FAIL r_route%0d: got v%b%b rdy%b want v%b%b rdy%b",
                 i, m1_r_valid, m0_r_valid, s_r_ready, sel, !sel,
                 sel ? r1 : r0);
      end
      step();
    end
    s_r_valid = 0;
    for (int i = 0; i < 8; i++) begin
      id = 6'($urandom_range(0, 31));
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      m0_b_ready = r0; m1_b_ready = r1;
      s_b_valid = 1; s_b_id = id; s_b_resp = 2'($urandom);
      #1;
      sel = (id >= 6'd16);
      checks++;
      if (m0_b_valid !== !sel || m1_b_valid !== sel ||
          (sel ? m1_b_id : m0_b_id) !== 4'(id % 16) ||
          s_b_ready !== (sel ? r1 : r0)) begin
        errors++;
        $display("FAIL b_route%0d: got v%b%b rdy%b want v%b%b rdy%b",
                 i, m1_b_valid, m0_b_valid, s_b_ready, sel, !sel,
                 sel ? r1 : r0);
      end
      step();
    end
    s_b_valid = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_aw_ready = 1; s_w_ready = 1;
    m0_aw_valid = 1; m0_aw_len = 8'd7;
    m0_ar_valid = 1;
    step();
    m0_aw_valid = 0; m0_ar_valid = 0;
    m0_w_valid = 1; m0_w_last = 0;
    step();
    step();
    #1;
    checks++;
    if (m0_w_ready !== 1'b1 || s_ar_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got w0r%b arv%b want 11", m0_w_ready, s_ar_valid);
    end
    reset = 1;
    m0_ar_valid = 1; m1_ar_valid = 1; m0_aw_valid = 1; m1_aw_valid = 1;
    s_ar_ready = 1;
    step();
    checks++;
    if ({s_ar_valid, s_aw_valid, s_w_valid, m0_w_ready, m1_w_ready,
         m0_ar_ready, m1_ar_ready, m0_aw_ready, m1_aw_ready} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b want 000000000",
               {s_ar_valid, s_aw_valid, s_w_valid, m0_w_ready, m1_w_ready,
                m0_ar_ready, m1_ar_ready, m0_aw_ready, m1_aw_ready});
    end
    reset = 0;
    #1;
    checks++;
    if (m0_ar_ready !== 1'b1 || m1_ar_ready !== 1'b0 ||
        m0_aw_ready !== 1'b1 || m1_aw_ready !== 1'b0 ||
        m0_w_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_reset: got ar%b%b aw%b%b w0r%b want ar01 aw01 w0r0",
               m1_ar_ready, m0_ar_ready, m1_aw_ready, m0_aw_ready, m0_w_ready);
    end
    step();
    idle_all();
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_ar_single();
    test_ar_rr();
    test_aw_order();
    test_ar_stall();
    test_r_interleave();
    test_random_ar();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
